// File: rtl/fft_s2p_buffer.sv
// Serial-to-parallel frame collector feeding the parallel FFT datapath.
// Gathers NUM complex samples and presents them as one registered frame, optionally bit-reversed.
module fft_s2p_buffer #(
  parameter int IN_WIDTH = 16,
  parameter int NUM      = 16,
  parameter bit BITREV   = 1'b0
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic signed [IN_WIDTH-1:0] din_i,
  input  logic signed [IN_WIDTH-1:0] din_q,
  input  logic                       valid_in,
  input  logic                       sof_in,
  output logic signed [IN_WIDTH-1:0] dout_i [0:NUM-1],
  output logic signed [IN_WIDTH-1:0] dout_q [0:NUM-1],
  output logic                       valid_out,
  output logic                       sof_err
);

  localparam int            AW   = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [AW-1:0] LAST = AW'(NUM - 1);

  logic signed [IN_WIDTH-1:0] fill_i [0:NUM-1];
  logic signed [IN_WIDTH-1:0] fill_q [0:NUM-1];

  logic [AW-1:0] wr_cnt;
  logic [AW-1:0] sample_idx;
  logic [AW-1:0] lane_idx;
  logic          sof_take;
  logic          frame_done;

  function automatic logic [AW-1:0] bit_reverse(input logic [AW-1:0] x);
    logic [AW-1:0] r;
    for (int b = 0; b < AW; b++) begin
      r[b] = x[AW-1-b];
    end
    return r;
  endfunction

  // A qualified sof forces the incoming sample to index 0, abandoning any partial frame.
  always_comb begin
    sof_take   = valid_in && sof_in;
    sample_idx = sof_take ? '0 : wr_cnt;
    lane_idx   = BITREV ? bit_reverse(sample_idx) : sample_idx;
    frame_done = valid_in && (sample_idx == LAST);
  end

  // Fill storage carries no reset; stale lanes are always overwritten before they are used.
  always_ff @(posedge clk) begin
    if (valid_in && !frame_done) begin
      fill_i[lane_idx] <= din_i;
      fill_q[lane_idx] <= din_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_cnt    <= '0;
      valid_out <= 1'b0;
      sof_err   <= 1'b0;
    end else begin
      valid_out <= frame_done;
      sof_err   <= sof_take && (wr_cnt != '0);
      if (valid_in) begin
        wr_cnt <= frame_done ? '0 : sample_idx + 1'b1;
      end
    end
  end

  // The final sample bypasses the fill buffer straight into its output lane.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int m = 0; m < NUM; m++) begin
        dout_i[m] <= '0;
        dout_q[m] <= '0;
      end
    end else if (frame_done) begin
      for (int m = 0; m < NUM; m++) begin
        dout_i[m] <= (lane_idx == AW'(m)) ? din_i : fill_i[m];
        dout_q[m] <= (lane_idx == AW'(m)) ? din_q : fill_q[m];
      end
    end
  end

endmodule
